// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
// Holds widths, the FSM state type and the pointer reset value,
// plus two small helpers used by the top-level datapath.
package rr_arbiter8_pkg;

  // Number of requesters and width of a requester index
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  // Search pointer value after reset: first search starts at requester 7
  localparam logic [ID_W-1:0] PTR_RESET = 3'd7;

  // Two-state arbitration FSM
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Rotate an 8-bit vector left by k positions
  function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  k);
    logic [2*N_REQ-1:0] dbl;
    dbl = {v, v} << k;
    return dbl[2*N_REQ-1:N_REQ];
  endfunction

  // One-hot decode of a requester index
  function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pri_enc8.sv
// 8-to-3 priority encoder: index of the highest set bit.
// IDX is 0 when no bit is set; ANY flags that at least one bit is set.
module pri_enc8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] V,
  output logic [ID_W-1:0]  IDX,
  output logic             ANY
);

  // Scan upward so the highest set bit overwrites lower ones
  always_comb begin
    IDX = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (V[i]) begin
        IDX = ID_W'(i);
      end
    end
  end

  assign ANY = |V;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin / fixed-priority arbiter for 8 requesters.
// A registered one-hot grant is held until the owner pulses DONE,
// drops its request, or has held the resource for HOLD_MAX cycles.
// Every tenure is followed by at least one idle cycle.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int HCW      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  input  logic             MODE,
  output logic [N_REQ-1:0] GNT,
  output logic [ID_W-1:0]  GNT_ID,
  output logic             GNT_VLD,
  output logic             TMO
);

  // Timeout is disabled entirely when HOLD_MAX is zero
  localparam bit              TMO_EN    = (HOLD_MAX != 0);
  localparam logic [HCW-1:0]  HOLD_LAST = TMO_EN ? HCW'(HOLD_MAX - 1) : '0;

  arb_state_e         state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [HCW-1:0]     hcnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic               tmo_q;

  logic [ID_W-1:0]    ptr_eff;
  logic [ID_W-1:0]    rot_amt;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    enc_idx;
  logic               enc_any;
  logic [ID_W-1:0]    winner_d;

  logic               rel_done;
  logic               rel_drop;
  logic               rel_tmo;
  logic               release_d;
  logic               tmo_only_d;

  // Fixed-priority mode behaves as round-robin with the pointer pinned at 7
  always_comb begin
    ptr_eff = MODE ? 3'd7 : ptr_q;
    rot_amt = 3'd7 - ptr_eff;
    req_rot = rotl8(REQ, rot_amt);
  end

  pri_enc8 u_pri_enc8 (
    .V   (req_rot),
    .IDX (enc_idx),
    .ANY (enc_any)
  );

  // Undo the rotation: rotated bit 7 corresponds to requester ptr_eff
  always_comb begin
    winner_d = enc_idx + ptr_eff + 3'd1;
  end

  // Release causes while a grant is active; TMO only when timeout acts alone
  always_comb begin
    rel_done   = DONE;
    rel_drop   = ~REQ[gnt_id_q];
    rel_tmo    = TMO_EN && (hcnt_q == HOLD_LAST);
    release_d  = rel_done | rel_drop | rel_tmo;
    tmo_only_d = rel_tmo & ~rel_done & ~rel_drop;
  end

  // Arbitration FSM with registered grant, id, pointer, hold counter and TMO
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RESET;
      hcnt_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tmo_q <= 1'b0;
          if (enc_any) begin
            state_q  <= ST_GRANT;
            gnt_q    <= onehot8(winner_d);
            gnt_id_q <= winner_d;
            hcnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_d) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= gnt_id_q - 3'd1;
            tmo_q   <= tmo_only_d;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
            tmo_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          tmo_q   <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign GNT_VLD = |gnt_q;
  assign TMO     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations
// plus a cycle-by-cycle reference model of the arbitration rules.
module tb_rr_arbiter8;

   localparam int HOLD = 4;

   logic       CLK;
   logic       RST;
   logic [7:0] REQ;
   logic       DONE;
   logic       MODE;
   logic [7:0] GNT;
   logic [2:0] GNT_ID;
   logic       GNT_VLD;
   logic       TMO;

   int compared;
   int mismatched;

   rr_arbiter8 #(.HOLD_MAX(HOLD), .HCW(8)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .REQ     (REQ),
      .DONE    (DONE),
      .MODE    (MODE),
      .GNT     (GNT),
      .GNT_ID  (GNT_ID),
      .GNT_VLD (GNT_VLD),
      .TMO     (TMO)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model state: who owns the resource and for how many cycles
   bit mReady;
   bit mBusy;
   int mOwner;
   int mPtr;
   int mHeld;
   bit mTmo;

   // Model update on each rising edge from the inputs present at that edge
   always @(posedge CLK) begin
      bit found;
      bit timedOut;
      bit dropped;
      int start;
      int idx;
      if (RST) begin
         mReady = 1'b1;
         mBusy  = 1'b0;
         mOwner = 0;
         mPtr   = 7;
         mHeld  = 0;
         mTmo   = 1'b0;
      end else if (!mBusy) begin
         mTmo = 1'b0;
         start = MODE ? 7 : mPtr;
         found = 1'b0;
         for (int k = 0; k < 8; k++) begin
            idx = (start - k + 8) % 8;
            if (!found && REQ[idx]) begin
               found  = 1'b1;
               mOwner = idx;
            end
         end
         if (found) begin
            mBusy = 1'b1;
            mHeld = 1;
         end
      end else begin
         timedOut = (HOLD > 0) && (mHeld == HOLD);
         dropped  = !REQ[mOwner];
         if (DONE || dropped || timedOut) begin
            mBusy = 1'b0;
            mPtr  = (mOwner + 7) % 8;
            mTmo  = timedOut && !DONE && !dropped;
         end else begin
            mHeld = mHeld + 1;
            mTmo  = 1'b0;
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge
   always @(negedge CLK) begin
      logic [7:0] expGnt;
      if (mReady) begin
         expGnt = mBusy ? (8'h01 << mOwner) : 8'h00;
         compared++;
         if (GNT !== expGnt || GNT_VLD !== mBusy || TMO !== mTmo ||
             (mBusy && GNT_ID !== 3'(mOwner))) begin
            mismatched++;
            $display("[TB] FAIL model t=%0t: got GNT=%h ID=%0d VLD=%b TMO=%b, want GNT=%h ID=%0d VLD=%b TMO=%b",
                     $time, GNT, GNT_ID, GNT_VLD, TMO, expGnt, mOwner, mBusy, mTmo);
         end
      end
   end

   // Drive one cycle of inputs and wait until just after the next rising edge
   task automatic applyStimulus(input logic r, input logic [7:0] q,
                                input logic d, input logic m);
      RST  = r;
      REQ  = q;
      DONE = d;
      MODE = m;
      @(posedge CLK);
      #2;
   endtask

   // Compare one observed value against a hand-computed expectation
   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
   endtask

   // Directed scenarios
   initial begin
      int ids3[9];
      ids3 = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      compared   = 0;
      mismatched = 0;
      mReady     = 1'b0;
      RST  = 1'b1;
      REQ  = 8'h00;
      DONE = 1'b0;
      MODE = 1'b0;

      // Reset dominates all-active inputs
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
         checkOutput("rst_gnt", GNT, 8'h00);
         checkOutput("rst_vld", {7'd0, GNT_VLD}, 8'h00);
         checkOutput("rst_id", {5'd0, GNT_ID}, 8'h00);
         checkOutput("rst_tmo", {7'd0, TMO}, 8'h00);
      end
      applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
      checkOutput("t1_first_id", {5'd0, GNT_ID}, 8'd7);
      checkOutput("t1_first_gnt", GNT, 8'h80);

      // Round-robin between requesters 7 and 0
      applyReset();
      applyStimulus(1'b0, 8'h81, 1'b0, 1'b0);
      checkOutput("t2_gnt7", GNT, 8'h80);
      applyStimulus(1'b0, 8'h81, 1'b1, 1'b0);
      checkOutput("t2_release", GNT, 8'h00);
      applyStimulus(1'b0, 8'h81, 1'b0, 1'b0);
      checkOutput("t2_gnt0", GNT, 8'h01);
      checkOutput("t2_id0", {5'd0, GNT_ID}, 8'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      // Full rotation with wrap from 0 back to 7
      applyReset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
         checkOutput($sformatf("t3_id%0d", i), {5'd0, GNT_ID}, 8'(ids3[i]));
         applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
         checkOutput($sformatf("t3_idle%0d", i), {7'd0, GNT_VLD}, 8'h00);
      end

      // Fixed priority keeps picking 7 until it withdraws
      applyReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1);
         checkOutput($sformatf("t4_id7_%0d", i), {5'd0, GNT_ID}, 8'd7);
         applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
      end
      applyStimulus(1'b0, 8'h7F, 1'b0, 1'b1);
      checkOutput("t4_id6", {5'd0, GNT_ID}, 8'd6);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

      // Timeout after HOLD cycles, then DONE coinciding with timeout
      applyReset();
      for (int i = 0; i < HOLD; i++) begin
         applyStimulus(1'b0, 8'h08, 1'b0, 1'b0);
         checkOutput($sformatf("t5_hold%0d", i), GNT, 8'h08);
      end
      applyStimulus(1'b0, 8'h08, 1'b0, 1'b0);
      checkOutput("t5_tmo_gnt", GNT, 8'h00);
      checkOutput("t5_tmo", {7'd0, TMO}, 8'h01);
      applyStimulus(1'b0, 8'h08, 1'b0, 1'b0);
      checkOutput("t5_regrant", GNT, 8'h08);
      checkOutput("t5_tmo_clr", {7'd0, TMO}, 8'h00);
      for (int i = 0; i < HOLD - 1; i++) begin
         applyStimulus(1'b0, 8'h08, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 8'h08, 1'b1, 1'b0);
      checkOutput("t5_done_tmo_gnt", GNT, 8'h00);
      checkOutput("t5_done_tmo", {7'd0, TMO}, 8'h00);

      // Release by request drop, then reset mid-grant
      applyReset();
      applyStimulus(1'b0, 8'h20, 1'b0, 1'b0);
      checkOutput("t6_gnt5", GNT, 8'h20);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t6_drop_gnt", GNT, 8'h00);
      checkOutput("t6_drop_tmo", {7'd0, TMO}, 8'h00);
      applyStimulus(1'b0, 8'h20, 1'b0, 1'b0);
      checkOutput("t6_regrant5", GNT, 8'h20);
      applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
      checkOutput("t6_rst_gnt", GNT, 8'h00);
      checkOutput("t6_rst_id", {5'd0, GNT_ID}, 8'h00);
      checkOutput("t6_rst_tmo", {7'd0, TMO}, 8'h00);
      applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
      checkOutput("t6_after_rst_id", {5'd0, GNT_ID}, 8'd7);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

      @(negedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
